// File: rtl/wb_regfile.sv
// Writeback stage and 32-entry general-purpose register file.
// Selects ALU or load data from MEM/WB, commits it to the register file, serves two
// combinational read ports with same-cycle write-through bypass, and tracks the last
// committed write plus a retired-instruction counter.
`timescale 1ns/1ps

module wb_regfile #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter logic [5:0]  NOOP_OP = 6'b111111,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hold,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [1:0]        i_wb,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_mem_out,
  input  logic [5:0]        i_operation,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic              o_wb_en,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [ADDR_W-1:0] o_last_rd,
  output logic [DATA_W-1:0] o_last_data,
  output logic [CNT_W-1:0]  o_retired
);

  localparam int unsigned NumRegs = 1 << ADDR_W;

  // Entry 0 is never written and always reset, so it stays zero and is trimmed in synthesis.
  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];

  logic [ADDR_W-1:0] last_rd_q,   last_rd_d;
  logic [DATA_W-1:0] last_data_q, last_data_d;
  logic [CNT_W-1:0]  retired_q,   retired_d;

  logic commit;
  logic wb_en;
  logic [DATA_W-1:0] wb_data;

  // Commit qualification and writeback data selection.
  always_comb begin
    commit  = !i_hold && (i_operation != NOOP_OP);
    wb_data = i_wb[0] ? i_mem_out : i_alu_result;
    wb_en   = commit && i_wb[1] && (i_rd != '0);
  end

  assign o_wb_en   = wb_en;
  assign o_wb_data = wb_data;

  // Next-state for register array, last-write tracking and retired counter.
  always_comb begin
    regs_d      = regs_q;
    last_rd_d   = last_rd_q;
    last_data_d = last_data_q;
    retired_d   = retired_q;
    if (wb_en) begin
      regs_d[i_rd] = wb_data;
      last_rd_d    = i_rd;
      last_data_d  = wb_data;
    end
    // Counts every committed non-bubble, including ones that do not write; wraps silently.
    if (commit) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // State registers; async reset clears everything and discards any in-flight commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      last_rd_q   <= '0;
      last_data_q <= '0;
      retired_q   <= '0;
    end else begin
      regs_q      <= regs_d;
      last_rd_q   <= last_rd_d;
      last_data_q <= last_data_d;
      retired_q   <= retired_d;
    end
  end

  // Read ports: r0 reads zero, a same-cycle write to the address bypasses the array.
  always_comb begin
    if (i_rs_addr == '0) begin
      o_rs_data = '0;
    end else if (wb_en && (i_rs_addr == i_rd)) begin
      o_rs_data = wb_data;
    end else begin
      o_rs_data = regs_q[i_rs_addr];
    end

    if (i_rt_addr == '0) begin
      o_rt_data = '0;
    end else if (wb_en && (i_rt_addr == i_rd)) begin
      o_rt_data = wb_data;
    end else begin
      o_rt_data = regs_q[i_rt_addr];
    end
  end

  assign o_last_rd   = last_rd_q;
  assign o_last_data = last_data_q;
  assign o_retired   = retired_q;

endmodule
